machine_display_scheduler: RTL and testbench
============================================

Name: machine_display_scheduler

Overview:
- Sequencing controller for the 4-digit 7-segment render datapath.
- Owns the digit registers and the multiplex timing.
- Produces the 20-bit render state word: four 4-bit digits plus an active-low anode select.
- Digit writes go through a valid/ready port into a shadow bank. The shadow bank is committed to the displayed bank only at a frame boundary, so the display never shows a half-updated value.

Parameters:
- CNT_W, 16, width of the dwell counter.
- DWELL, 50000, clock cycles each digit is lit. Legal range 2..2^CNT_W-1.

Ports:
- system1000  in  1  clock; all state changes on its rising edge.
- system1000_rstn  in  1  asynchronous, active-low reset.
- enable  in  1  1 = scan the display; 0 = blank the display and hold the scan at its start.
- wr_valid  in  1  digit write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_index  in  2  shadow digit position, 0..3.
- wr_data  in  4  shadow digit value.
- commit  in  1  one-cycle pulse; requests a shadow-to-active copy.
- commit_pending  out  1  a commit request is waiting for a frame boundary.
- frame_tick  out  1  one-cycle pulse marking the first cycle of a new frame.
- s  out  20  render word, laid out as {act0, act1, act2, act3, anode_n}.

Behaviour:
- Reset values (async assert, sync release):
  - shadow and active banks = 0.
  - cnt = 0, pos = 0.
  - s = {16'h0000, 4'b1111}.
  - wr_ready = 1, commit_pending = 0, frame_tick = 0.
- Anode encoding, registered from pos: 0→1110, 1→1101, 2→1011, 3→0111. When enable = 0, anode_n = 1111.
- Dwell counter:
  - With enable = 1: cnt increments each cycle and wraps DWELL-1 → 0.
  - At the wrap, pos advances 0→1→2→3→0.
  - The new anode_n appears on s in the cycle after the wrap (one-cycle registered latency).
- Frame boundary (fb): enable && pos == 3 && cnt == DWELL-1.
- Scan state machine:
  - SCAN, while enable = 1: normal counting and rotation as above.
  - BLANK, while enable = 0: cnt = 0, pos = 0, anode_n = 1111.
  - BLANK → SCAN on enable rising: pos 0 is lit for a full DWELL starting the next cycle.
  - SCAN → BLANK on enable falling: anode_n = 1111 the next cycle; the scan position and count are discarded.
- Writes:
  - Accepted write sets shadow[wr_index] = wr_data on the clock edge.
  - wr_ready = 0 only in the swap cycle (defined below); otherwise 1.
  - An unaccepted write has no effect.
- Commit:
  - The commit pulse sets commit_pending.
  - Swap cycle = the cycle in which (commit_pending && fb) or (commit_pending && !enable).
  - In the swap cycle: active bank = shadow bank, commit_pending cleared.
  - The new digits appear on s in the same cycle as pos 0's anode. When disabled, they appear next cycle.
  - Commit arriving in a swap cycle: it re-arms commit_pending for the following boundary. Pending stays set; no double count.
  - Repeated commit pulses while pending are absorbed; one swap occurs.
- frame_tick: registered, high exactly one cycle after each fb. Never high while enable = 0.
- Digit-field mapping: act0 in s[19:16] through act3 in s[7:4]. Display position k shows actk.
- Reset mid-scan: all state returns to reset values immediately; pending commits and unswapped shadow data are lost.

Decomposition:
- Package machine_display_pkg holds:
  - NUM_DIGITS = 4.
  - DIGIT_W = 4.
  - ANODE_OFF = 4'b1111.
  - anode_encode(pos) function.
  - render word field offsets.
- Sub-module machine_dwell_prescaler (parameters CNT_W and DWELL):
  - Inputs: clock, reset, enable.
  - Outputs: cnt and a wrap strobe.
- The top level holds the pos register, both banks, commit logic and output registers.

Test Plan (DWELL=4):
- Reset release, enable = 0 → s = 20'h0000F, wr_ready = 1, frame_tick never pulses over 50 cycles.
- enable = 1 at cycle 0 → anode_n sequence 1110 ×4, 1101 ×4, 1011 ×4, 0111 ×4, repeating; frame_tick pulse every 16 cycles, coincident with the return to 1110.
- Writes {0:1, 1:2, 2:3, 3:4} then commit mid-frame → digits stay 0 and commit_pending = 1 until the boundary; then s[19:4] = 16'h1234 with anode 1110 and pending = 0.
- wr_valid held with data 9 to index 2 across a boundary with commit pending → wr_ready = 0 only in the swap cycle; the write lands the next cycle; it is displayed only after a second commit.
- Commit pulsed while enable = 0 → active bank updated the next cycle; anode_n stays 1111.
- Assert reset at pos = 2 with commit pending → s = 20'h0000F, commit_pending = 0; after release and enable, scan restarts at 1110 with a full 4-cycle dwell.

Source files
------------

// File: rtl/machine_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : machine_display_pkg
// Description : Shared constants, scan-state type and helpers for the
//               4-digit 7-segment display scheduler.
//               Render word layout: {act0, act1, act2, act3, anode_n}
//               with act0 in the most significant nibble.
// Revision    : 1.0 - initial release
// ============================================================================
package machine_display_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 4;
    localparam int POS_W      = 2;
    localparam int ANODE_W    = 4;

    localparam logic [ANODE_W-1:0] ANODE_OFF = 4'b1111;

    // Render word field offsets
    localparam int S_W        = NUM_DIGITS * DIGIT_W + ANODE_W;
    localparam int ANODE_LSB  = 0;
    localparam int DIGIT0_LSB = S_W - DIGIT_W;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SCAN  = 1'b1
    } scan_state_e;

    // LSB of digit k inside the render word (digit 0 sits highest)
    function automatic int digit_lsb(input int k);
        return DIGIT0_LSB - k * DIGIT_W;
    endfunction

    // Active-low one-hot anode select for a display position
    function automatic logic [ANODE_W-1:0] anode_encode(input logic [POS_W-1:0] pos);
        logic [ANODE_W-1:0] anode;
        case (pos)
            2'd0:    anode = 4'b1110;
            2'd1:    anode = 4'b1101;
            2'd2:    anode = 4'b1011;
            default: anode = 4'b0111;
        endcase
        return anode;
    endfunction

endpackage
`default_nettype wire

// File: rtl/machine_display_scheduler_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : machine_dwell_prescaler
// Description : Dwell counter for the display multiplexer. Counts while
//               enabled, wraps DWELL-1 -> 0 and strobes o_wrap in the last
//               cycle of each dwell. Held at zero while disabled.
// Ports       : clk     - clock
//               rst_n   - asynchronous active-low reset
//               i_en    - count enable
//               o_cnt   - current dwell count
//               o_wrap  - high in the cycle the count is DWELL-1 (enabled)
// Revision    : 1.0 - initial release
// ============================================================================
module machine_dwell_prescaler
    import machine_display_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int DWELL = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_wrap
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             w_wrap;

    always_comb begin
        w_wrap = i_en && (cnt_q == c_cnt_last);
        cnt_d  = cnt_q;
        if (!i_en || w_wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + c_cnt_one;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt  = cnt_q;
    assign o_wrap = w_wrap;

endmodule
`default_nettype wire

// File: rtl/machine_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : machine_display_scheduler
// Description : Sequencing controller for the 4-digit 7-segment render path.
//               Holds a shadow digit bank written through a valid/ready port
//               and an active bank that is refreshed from the shadow bank
//               only at a frame boundary (or at once while blanked), so the
//               display never shows a half-updated value.
// Ports       : system1000      - clock
//               system1000_rstn - asynchronous active-low reset
//               enable          - 1 = scan, 0 = blank and hold scan at start
//               wr_valid/ready  - shadow digit write handshake
//               wr_index/data   - shadow digit position / value
//               commit          - pulse requesting shadow -> active copy
//               commit_pending  - commit waiting for a frame boundary
//               frame_tick      - first cycle of a new frame
//               s               - render word {act0..act3, anode_n}
// Revision    : 1.0 - initial release
// ============================================================================
module machine_display_scheduler
    import machine_display_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int DWELL = 50000
) (
    input  logic               system1000,
    input  logic               system1000_rstn,
    input  logic               enable,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [POS_W-1:0]   wr_index,
    input  logic [DIGIT_W-1:0] wr_data,
    input  logic               commit,
    output logic               commit_pending,
    output logic               frame_tick,
    output logic [S_W-1:0]     s
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DWELL - 1);
    localparam logic [POS_W-1:0] c_pos_last = POS_W'(NUM_DIGITS - 1);
    localparam logic [POS_W-1:0] c_pos_one  = POS_W'(1);

    scan_state_e                             state_q;
    scan_state_e                             state_d;
    logic [POS_W-1:0]                        pos_q;
    logic [POS_W-1:0]                        pos_d;
    logic [ANODE_W-1:0]                      anode_q;
    logic [ANODE_W-1:0]                      anode_d;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]      shadow_q;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]      shadow_d;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]      active_q;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]      active_d;
    logic                                    commit_pending_q;
    logic                                    commit_pending_d;
    logic                                    frame_tick_q;
    logic                                    frame_tick_d;

    logic [CNT_W-1:0]                        w_cnt;
    logic                                    w_wrap;
    logic                                    w_run;
    logic                                    w_fb;
    logic                                    w_swap;
    logic                                    w_wr_fire;

    // The counter only runs once the scan state has been entered: the cycle
    // in which enable rises is spent preloading anode 1110, so position 0
    // is then lit for a full dwell.
    assign w_run = (state_q == ST_SCAN) && enable;

    machine_dwell_prescaler #(
        .CNT_W (CNT_W),
        .DWELL (DWELL)
    ) u_prescaler (
        .clk    (system1000),
        .rst_n  (system1000_rstn),
        .i_en   (w_run),
        .o_cnt  (w_cnt),
        .o_wrap (w_wrap)
    );

    // Last cycle of position 3: the next cycle starts a new frame
    assign w_fb      = enable && (pos_q == c_pos_last) && (w_cnt == c_cnt_last);
    assign w_swap    = commit_pending_q && (w_fb || !enable);
    // The shadow bank is frozen during the copy so the swap sees a stable
    // snapshot; a write offered then is simply held off for one cycle.
    assign w_wr_fire = wr_valid && !w_swap;

    always_comb begin
        state_d          = state_q;
        pos_d            = pos_q;
        anode_d          = anode_q;
        shadow_d         = shadow_q;
        active_d         = active_q;
        commit_pending_d = commit_pending_q;
        frame_tick_d     = 1'b0;

        // Scan state machine
        case (state_q)
            ST_BLANK: state_d = enable ? ST_SCAN : ST_BLANK;
            ST_SCAN:  state_d = enable ? ST_SCAN : ST_BLANK;
            default:  state_d = ST_BLANK;
        endcase

        if (!enable) begin
            pos_d = '0;
        end else if (w_wrap) begin
            pos_d = pos_q + c_pos_one;
        end

        // Anode is registered from the next position so it changes in the
        // same cycle as pos and lines up with frame_tick and the bank swap.
        anode_d = enable ? anode_encode(pos_d) : ANODE_OFF;

        if (w_wr_fire) begin
            shadow_d[wr_index] = wr_data;
        end

        if (w_swap) begin
            active_d         = shadow_q;
            // A commit landing in the swap cycle arms the next boundary
            commit_pending_d = commit;
        end else begin
            commit_pending_d = commit_pending_q | commit;
        end

        frame_tick_d = w_fb;
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state_q          <= ST_BLANK;
            pos_q            <= '0;
            anode_q          <= ANODE_OFF;
            shadow_q         <= '0;
            active_q         <= '0;
            commit_pending_q <= 1'b0;
            frame_tick_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            pos_q            <= pos_d;
            anode_q          <= anode_d;
            shadow_q         <= shadow_d;
            active_q         <= active_d;
            commit_pending_q <= commit_pending_d;
            frame_tick_q     <= frame_tick_d;
        end
    end

    // Render word assembly
    generate
        for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digits
            localparam int c_lsb = digit_lsb(k);
            assign s[c_lsb +: DIGIT_W] = active_q[k];
        end
    endgenerate

    assign s[ANODE_LSB +: ANODE_W] = anode_q;

    assign wr_ready       = !w_swap;
    assign commit_pending = commit_pending_q;
    assign frame_tick     = frame_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_machine_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_machine_display_scheduler
// Description : Self-checking bench for machine_display_scheduler (DWELL=4).
//               Driver issues per-cycle stimulus and pushes the expected
//               outputs from a frame/phase-level reference model; a monitor
//               on the falling edge pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_machine_display_scheduler;

    localparam int DW    = 4;
    localparam int FRAME = 4 * DW;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        enable   = 1'b0;
    logic        wr_valid = 1'b0;
    logic [1:0]  wr_index = 2'd0;
    logic [3:0]  wr_data  = 4'd0;
    logic        commit   = 1'b0;
    logic        wr_ready;
    logic        commit_pending;
    logic        frame_tick;
    logic [19:0] s;

    machine_display_scheduler #(
        .CNT_W (16),
        .DWELL (DW)
    ) dut (
        .system1000      (clk),
        .system1000_rstn (rst_n),
        .enable          (enable),
        .wr_valid        (wr_valid),
        .wr_ready        (wr_ready),
        .wr_index        (wr_index),
        .wr_data         (wr_data),
        .commit          (commit),
        .commit_pending  (commit_pending),
        .frame_tick      (frame_tick),
        .s               (s)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [19:0] s;
        logic        rdy;
        logic        pend;
        logic        ft;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    // Reference model: m_lit is the index of the current lit cycle within
    // the frame (0..FRAME-1), or -1 while the display is dark.
    logic [3:0] m_shadow [4];
    logic [3:0] m_active [4];
    logic       m_pending;
    logic       m_ft;
    int         m_lit;

    function automatic logic [3:0] anode_of(input int lit);
        logic [3:0] one;
        if (lit < 0) return 4'b1111;
        one = 4'b0001;
        return ~(one << ((lit / DW) % 4));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_shadow[k] = 4'd0;
            m_active[k] = 4'd0;
        end
        m_pending = 1'b0;
        m_ft      = 1'b0;
        m_lit     = -1;
    endtask

    task automatic model_step();
        exp_t e;
        logic fb;
        logic swap;
        if (!rst_n) begin
            model_reset();
            e.s    = 20'h0000F;
            e.rdy  = 1'b1;
            e.pend = 1'b0;
            e.ft   = 1'b0;
            exp_q.push_back(e);
            return;
        end
        fb   = enable && (m_lit >= 0) && ((m_lit + 1) % FRAME == 0);
        swap = m_pending && (fb || !enable);
        e.s[3:0] = anode_of(m_lit);
        for (int k = 0; k < 4; k++) e.s[19 - 4*k -: 4] = m_active[k];
        e.rdy  = !swap;
        e.pend = m_pending;
        e.ft   = m_ft;
        exp_q.push_back(e);
        // next state
        if (swap) begin
            for (int k = 0; k < 4; k++) m_active[k] = m_shadow[k];
            m_pending = commit;
        end else begin
            m_pending = m_pending | commit;
        end
        if (wr_valid && !swap) m_shadow[wr_index] = wr_data;
        m_ft  = fb;
        m_lit = enable ? ((m_lit < 0) ? 0 : (m_lit + 1) % FRAME) : -1;
    endtask

    task automatic drive(input logic rn, input logic en, input logic wv,
                         input logic [1:0] idx, input logic [3:0] d, input logic cm);
        @(posedge clk);
        #1;
        rst_n    = rn;
        enable   = en;
        wr_valid = wv;
        wr_index = idx;
        wr_data  = d;
        commit   = cm;
        model_step();
        cyc++;
    endtask

    task automatic idle(input int n, input logic en);
        for (int i = 0; i < n; i++) drive(1'b1, en, 1'b0, 2'd0, 4'd0, 1'b0);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({s, wr_ready, commit_pending, frame_tick} !== e) begin
                errors++;
                $display("FAIL outputs cycle %0d: got s=%h rdy=%b pend=%b ft=%b, want s=%h rdy=%b pend=%b ft=%b",
                         cyc, s, wr_ready, commit_pending, frame_tick, e.s, e.rdy, e.pend, e.ft);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int en_r;
        model_reset();
        // Reset, then 50 cycles disabled
        drive(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
        idle(50, 1'b0);
        // Free-running scan
        idle(40, 1'b1);
        // Writes 1,2,3,4 then commit mid-frame
        for (int k = 0; k < 4; k++) drive(1'b1, 1'b1, 1'b1, 2'(k), 4'(k + 1), 1'b0);
        drive(1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 1'b1);
        idle(24, 1'b1);
        // Held write of 9 to index 2 across a boundary with commit pending
        drive(1'b1, 1'b1, 1'b1, 2'd2, 4'd9, 1'b1);
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 1'b1, 2'd2, 4'd9, 1'b0);
        idle(3, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 1'b1);   // absorbed repeat
        idle(20, 1'b1);
        // Commit while disabled
        idle(3, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 2'd0, 4'd7, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b1);
        idle(5, 1'b0);
        // Reset at pos 2 with commit pending
        idle(1 + 2 * DW + 1, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 2'd3, 4'd5, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0);
        idle(2, 1'b0);
        idle(24, 1'b1);
        // Randomized traffic
        en_r = 1;
        for (int i = 0; i < 1500; i++) begin
            logic rn;
            if ($urandom_range(0, 59) == 0) en_r = 1 - en_r;
            rn = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            drive(rn, 1'(en_r), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)), ($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0);
        end
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
